cpu_bus_ctrl: RTL

CPU_BUS_CTRL -- requirements
Module: cpu_bus_ctrl

---
 rtl/cpu_bus_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/cpu_bus_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_bus_ctrl
//
// Address decoder and read-data steering for a 6510-style CPU bus with a
// fixed memory map. The CPU's on-chip I/O port (DDR at $0000, data at $0001)
// sets the banking bits LORAM/HIRAM/CHAREN. These bits decide whether BASIC
// ROM ($A000-$BFFF), KERNAL ROM ($E000-$FFFF) and the $D000-$DFFF window
// (I/O or character ROM) are visible to reads. Writes always fall through to
// the underlying RAM, except for writes into the I/O window.
//
// Every attached memory has one cycle of synchronous read latency. The
// decoded region is therefore registered, and cpu_di is steered by that
// registered region. Data returns exactly one cycle after the address.
//
// Optional feature macro: CPU_BUS_CHARROM_EN
//   defined   : CHAREN chooses character ROM (0) or I/O (1) in $D000-$DFFF.
//   undefined : CHAREN is ignored. $D000-$DFFF is I/O whenever LORAM|HIRAM,
//               and char_addr is tied to zero.
//
// Ports
//   clk          in   1   single clock, rising edge
//   reset        in   1   synchronous active-high reset
//   ab           in   16  CPU address bus
//   cpu_do       in   8   CPU write data
//   we           in   1   CPU write enable (1 = write cycle)
//   cpu_di       out  8   read data returned to the CPU
//   ram_addr     out  16  RAM address (copy of ab)
//   ram_wdata    out  8   RAM write data (copy of cpu_do)
//   ram_we       out  1   RAM write strobe
//   ram_rdata    in   8   RAM read data (1-cycle latency)
//   basic_addr   out  13  BASIC ROM address
//   basic_data   in   8   BASIC ROM data
//   kernal_addr  out  13  KERNAL ROM address
//   kernal_data  in   8   KERNAL ROM data
//   char_addr    out  12  character ROM address
//   char_data    in   8   character ROM data
//   io_sel       out  1   access currently targets the I/O window
//   io_we        out  1   I/O write strobe
//   io_addr      out  12  I/O register address
//   io_rdata     in   8   I/O read data (1-cycle latency)
//   port_in      in   8   external levels on the CPU port pins
//   port_out     out  8   effective CPU port pin levels
// ---------------------------------------------------------------------------
module cpu_bus_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] ab,
    input  logic [7:0]  cpu_do,
    input  logic        we,
    output logic [7:0]  cpu_di,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_wdata,
    output logic        ram_we,
    input  logic [7:0]  ram_rdata,
    output logic [12:0] basic_addr,
    input  logic [7:0]  basic_data,
    output logic [12:0] kernal_addr,
    input  logic [7:0]  kernal_data,
    output logic [11:0] char_addr,
    input  logic [7:0]  char_data,
    output logic        io_sel,
    output logic        io_we,
    output logic [11:0] io_addr,
    input  logic [7:0]  io_rdata,
    input  logic [7:0]  port_in,
    output logic [7:0]  port_out
);

    // Read source for the access on the bus. Code 3'd7 is never produced by
    // the decoder. It reads back as $FF so that a corrupted region register
    // is visible.
    typedef enum logic [2:0] {
        REG_RAM    = 3'd0,
        REG_DDR    = 3'd1,
        REG_PORT   = 3'd2,
        REG_BASIC  = 3'd3,
        REG_KERNAL = 3'd4,
        REG_IO     = 3'd5,
        REG_CHAR   = 3'd6
    } region_t;

    logic [7:0] ddr_reg;
    logic [7:0] data_reg;
    logic [7:0] ddr_cap_reg;
    logic [7:0] port_cap_reg;
    region_t    region_reg;
    region_t    region_next;

    logic [7:0] eff;
    logic [7:0] port_rd;
    logic       loram;
    logic       hiram;

    // A pin whose DDR bit is 0 is an input. For banking it floats high
    // (pull-up), so eff reads 1 there. For CPU reads of $0001 it returns the
    // external pin level instead.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_port_bit
            assign eff[gi]     = ddr_reg[gi] ? data_reg[gi] : 1'b1;
            assign port_rd[gi] = ddr_reg[gi] ? data_reg[gi] : port_in[gi];
        end
    endgenerate

    assign loram    = eff[0];
    assign hiram    = eff[1];
    assign port_out = eff;

    // Address decode. It uses the banking registers as they stand before
    // this cycle's edge. A write to $0001 therefore only changes the decode
    // of the following access.
    always_comb begin
        region_next = REG_RAM;
        if (ab == 16'h0000) begin
            region_next = REG_DDR;
        end else if (ab == 16'h0001) begin
            region_next = REG_PORT;
        end else if (ab[15:13] == 3'b101) begin
            region_next = (loram & hiram) ? REG_BASIC : REG_RAM;
        end else if (ab[15:13] == 3'b111) begin
            region_next = hiram ? REG_KERNAL : REG_RAM;
        end else if (ab[15:12] == 4'hD) begin
            if (loram | hiram) begin
`ifdef CPU_BUS_CHARROM_EN
                region_next = eff[2] ? REG_IO : REG_CHAR;
`else
                region_next = REG_IO;
`endif
            end
        end
    end

    // Memory addresses are plain copies of the bus. The attached memories
    // register them, which provides the one-cycle read latency.
    assign ram_addr    = ab;
    assign ram_wdata   = cpu_do;
    assign basic_addr  = ab[12:0];
    assign kernal_addr = ab[12:0];
    assign io_addr     = ab[11:0];
`ifdef CPU_BUS_CHARROM_EN
    assign char_addr   = ab[11:0];
`else
    assign char_addr   = 12'h000;
`endif

    // The I/O window is the only region that shadows RAM for writes. ROM
    // regions and the on-chip port all write through to RAM.
    assign io_sel = (region_next == REG_IO);
    assign io_we  = we & io_sel & ~reset;
    assign ram_we = we & ~io_sel & ~reset;

    // Port registers and the pending read selection. The DDR and port read
    // values are captured at the same edge as the region, so a read of
    // $0000/$0001 returns the values that held during the address cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            ddr_reg      <= 8'h00;
            data_reg     <= 8'h00;
            ddr_cap_reg  <= 8'h00;
            port_cap_reg <= 8'h00;
            region_reg   <= REG_RAM;
        end else begin
            region_reg   <= region_next;
            ddr_cap_reg  <= ddr_reg;
            port_cap_reg <= port_rd;
            if (we && (ab == 16'h0000)) begin
                ddr_reg <= cpu_do;
            end
            if (we && (ab == 16'h0001)) begin
                data_reg <= cpu_do;
            end
        end
    end

    // Read data steering for the access presented one cycle earlier. It is
    // forced to zero while reset is held.
    always_comb begin
        cpu_di = 8'h00;
        if (!reset) begin
            case (region_reg)
                REG_RAM:    cpu_di = ram_rdata;
                REG_DDR:    cpu_di = ddr_cap_reg;
                REG_PORT:   cpu_di = port_cap_reg;
                REG_BASIC:  cpu_di = basic_data;
                REG_KERNAL: cpu_di = kernal_data;
                REG_IO:     cpu_di = io_rdata;
                REG_CHAR:   cpu_di = char_data;
                default:    cpu_di = 8'hFF;
            endcase
        end
    end

endmodule
